// File: rtl/i2c_seg_target.sv
`timescale 1ns/1ps
// I2C write-only target for the segment display link: oversamples SCL/SDA, ACKs its
// own address and latches pointer-addressed data bytes into a local register bank.
module i2c_seg_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h38,
    parameter int         NUM_REGS    = 8,
    parameter int         SYNC_STAGES = 2,
    localparam int        AW          = $clog2(NUM_REGS)
) (
    input  logic                  clk_100,
    input  logic                  reset,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic                  wr_strobe,
    output logic [AW-1:0]         wr_addr,
    output logic [7:0]            wr_data,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  busy,
    output logic [7:0]            nack_cnt
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_PTR      = 3'd3,
        ST_PTR_ACK  = 3'd4,
        ST_DATA     = 3'd5,
        ST_DATA_ACK = 3'd6,
        ST_IGNORE   = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0]   scl_sync_r, sda_sync_r;
    logic                     scl_prev_r, sda_prev_r;
    logic                     scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
    state_t                   state_r, state_nxt_s;
    logic [2:0]               bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0]               shift_r, shift_nxt_s, byte_s;
    logic                     ack_phase_r, ack_phase_nxt_s;
    logic [AW-1:0]            ptr_r, ptr_nxt_s;
    logic                     addressed_r, addressed_nxt_s;
    logic                     sda_oe_r, sda_oe_nxt_s;
    logic                     busy_r, busy_nxt_s;
    logic                     commit_s, nack_inc_s;
    logic                     wr_strobe_r;
    logic [AW-1:0]            wr_addr_r;
    logic [7:0]               wr_data_r, nack_cnt_r;
    logic [NUM_REGS-1:0][7:0] regs_r;

    // Bus line synchronizers plus the previous-value stage used for edge detection
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
            scl_prev_r <= scl_sync_r[SYNC_STAGES-1];
            sda_prev_r <= sda_sync_r[SYNC_STAGES-1];
        end
    end

    assign scl_s      = scl_sync_r[SYNC_STAGES-1];
    assign sda_s      = sda_sync_r[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_prev_r;
    assign scl_fall_s = ~scl_s & scl_prev_r;
    // SDA may only move while SCL is stable high for a START/STOP to count
    assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
    assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
    assign byte_s     = {shift_r[6:0], sda_s};

    // Next-state, shift/count, pointer and ACK-drive decisions
    always_comb begin
        state_nxt_s     = state_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        shift_nxt_s     = shift_r;
        ack_phase_nxt_s = ack_phase_r;
        ptr_nxt_s       = ptr_r;
        addressed_nxt_s = addressed_r;
        sda_oe_nxt_s    = 1'b0;
        commit_s        = 1'b0;
        nack_inc_s      = 1'b0;
        busy_nxt_s      = 1'b0;
        if (start_s) begin
            state_nxt_s     = ST_ADDR;
            bit_cnt_nxt_s   = 3'd0;
            ack_phase_nxt_s = 1'b0;
        end else if (stop_s) begin
            state_nxt_s     = ST_IDLE;
            bit_cnt_nxt_s   = 3'd0;
            ack_phase_nxt_s = 1'b0;
            addressed_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_ADDR, ST_PTR, ST_DATA: begin
                    if (scl_rise_s) begin
                        shift_nxt_s   = byte_s;
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r != 3'd7) begin
                            state_nxt_s = state_r;
                        end else if (state_r == ST_ADDR) begin
                            if (byte_s[7:1] == DEV_ADDR && byte_s[0] == 1'b0) begin
                                state_nxt_s     = ST_ADDR_ACK;
                                addressed_nxt_s = 1'b1;
                            end else begin
                                state_nxt_s     = ST_IGNORE;
                                addressed_nxt_s = 1'b0;
                                nack_inc_s      = 1'b1;
                            end
                        end else if (state_r == ST_PTR) begin
                            state_nxt_s = ST_PTR_ACK;
                            ptr_nxt_s   = byte_s[AW-1:0];
                        end else begin
                            state_nxt_s = ST_DATA_ACK;
                            commit_s    = 1'b1;
                            ptr_nxt_s   = ptr_r + AW'(1'b1);
                        end
                    end else begin
                        shift_nxt_s = shift_r;
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_DATA_ACK: begin
                    // phase 0 waits for the fall ending bit 8, phase 1 drives until the ACK clock ends
                    sda_oe_nxt_s = ack_phase_r;
                    if (scl_fall_s) begin
                        if (!ack_phase_r) begin
                            ack_phase_nxt_s = 1'b1;
                            sda_oe_nxt_s    = 1'b1;
                        end else begin
                            ack_phase_nxt_s = 1'b0;
                            sda_oe_nxt_s    = 1'b0;
                            state_nxt_s     = (state_r == ST_ADDR_ACK) ? ST_PTR : ST_DATA;
                        end
                    end else begin
                        ack_phase_nxt_s = ack_phase_r;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    state_nxt_s = state_r;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
        case (state_nxt_s)
            ST_ADDR_ACK, ST_PTR, ST_PTR_ACK, ST_DATA, ST_DATA_ACK: busy_nxt_s = 1'b1;
            ST_ADDR: busy_nxt_s = addressed_nxt_s;
            default: busy_nxt_s = 1'b0;
        endcase
    end

    // FSM state and protocol bookkeeping registers
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            ack_phase_r <= 1'b0;
            ptr_r       <= '0;
            addressed_r <= 1'b0;
            sda_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            shift_r     <= shift_nxt_s;
            ack_phase_r <= ack_phase_nxt_s;
            ptr_r       <= ptr_nxt_s;
            addressed_r <= addressed_nxt_s;
            sda_oe_r    <= sda_oe_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    // Register bank, commit port and NACK counter
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= 8'h00;
            regs_r      <= '0;
            nack_cnt_r  <= 8'h00;
        end else begin
            wr_strobe_r <= commit_s;
            if (commit_s) begin
                wr_addr_r     <= ptr_r;
                wr_data_r     <= byte_s;
                regs_r[ptr_r] <= byte_s;
            end
            if (nack_inc_s && nack_cnt_r != 8'hFF) begin
                nack_cnt_r <= nack_cnt_r + 8'd1;
            end
        end
    end

    assign sda_oe    = sda_oe_r;
    assign wr_strobe = wr_strobe_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign regs_flat = regs_r;
    assign busy      = busy_r;
    assign nack_cnt  = nack_cnt_r;

endmodule

// File: tb/tb_i2c_seg_target.sv
`timescale 1ns/1ps
// Bench for i2c_seg_target: drives an I2C controller model on an open-drain bus and
// compares ACKs, commits, register bank and counters against a transaction-level model.
module tb_i2c_seg_target;
    localparam int         NR  = 8;
    localparam logic [7:0] WR_ADDR_BYTE = 8'h70;

    logic             clk_100 = 1'b0;
    logic             reset;
    logic             scl_m, sda_m;
    logic             sda_oe, wr_strobe, busy;
    logic [2:0]       wr_addr;
    logic [7:0]       wr_data, nack_cnt;
    logic [8*NR-1:0]  regs_flat;
    wire              sda_bus = sda_m & ~sda_oe;

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         phase  = 8;
    logic [7:0] m_regs [NR];
    int         m_ptr  = 0;
    int         m_nack = 0;
    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];
    logic [7:0]  tx_q[$];
    int          seg_acks;
    logic        seg_addr;
    logic        stb_prev = 1'b0;

    typedef struct {
        int          n;
        logic [31:0] bytes;
        int          acks;
        int          nack;
        int          writes;
        int          first;
        int          ridx;
        logic [7:0]  rval;
    } vec_t;
    vec_t vecs [5];

    always #5 clk_100 = ~clk_100;

    i2c_seg_target dut (
        .clk_100   (clk_100),
        .reset     (reset),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .regs_flat (regs_flat),
        .busy      (busy),
        .nack_cnt  (nack_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Commit monitor: records every strobe and checks it is a single-cycle pulse
    initial begin
        forever begin
            @(negedge clk_100);
            if (wr_strobe) begin
                obs_q.push_back({wr_addr, wr_data});
                chk("strobe_width", {63'd0, stb_prev}, 64'd0);
            end
            stb_prev = wr_strobe;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_100);
        #1;
    endtask

    task automatic bus_start();
        if (!scl_m) begin
            cyc(2); sda_m = 1'b1; cyc(phase - 2); scl_m = 1'b1; cyc(phase);
        end
        sda_m = 1'b0; cyc(phase); scl_m = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        cyc(2); sda_m = b; cyc(phase - 2); scl_m = 1'b1; cyc(phase); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        cyc(2); sda_m = 1'b1; cyc(phase - 2); scl_m = 1'b1;
        cyc(phase / 2); ack = ~sda_bus;
        cyc(phase - phase / 2); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        cyc(2); sda_m = 1'b0; cyc(phase - 2); scl_m = 1'b1; cyc(phase); sda_m = 1'b1; cyc(phase);
    endtask

    task automatic set_tx(input logic [31:0] bytes, input int n);
        logic [31:0] b;
        b = bytes;
        tx_q.delete();
        for (int i = 0; i < n; i++) begin
            tx_q.push_back(b[31:24]);
            b = b << 8;
        end
    endtask

    // One START-delimited segment; the model decides ACKs and writes from the byte list
    task automatic run_seg(input logic rs_chk);
        logic ack, exp_ack;
        bus_start();
        if (rs_chk) begin
            cyc(4);
            chk("busy_after_rstart", {63'd0, busy}, 64'd1);
        end
        seg_acks = 0;
        seg_addr = (tx_q[0] == WR_ADDR_BYTE);
        if (!seg_addr && m_nack < 255) m_nack++;
        for (int i = 0; i < tx_q.size(); i++) begin
            exp_ack = seg_addr;
            if (seg_addr && i == 1) begin
                m_ptr = tx_q[i] % NR;
            end else if (seg_addr && i >= 2) begin
                m_regs[m_ptr] = tx_q[i];
                exp_q.push_back({m_ptr[2:0], tx_q[i]});
                m_ptr = (m_ptr + 1) % NR;
            end
            send_byte(tx_q[i], ack);
            if (ack) seg_acks++;
            chk($sformatf("ack_byte%0d_%02h", i, tx_q[i]), {63'd0, ack}, {63'd0, exp_ack});
        end
        cyc(4);
        chk("busy_in_seg", {63'd0, busy}, {63'd0, seg_addr});
    endtask

    task automatic check_all(input string tag);
        logic [8*NR-1:0] flat;
        cyc(4);
        for (int k = 0; k < NR; k++) flat[8*k +: 8] = m_regs[k];
        chk({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
        chk({tag, "_nack_cnt"}, {56'd0, nack_cnt}, 64'(m_nack));
        chk({tag, "_regs_flat"}, regs_flat, flat);
        chk({tag, "_strobe_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk({tag, "_commit"}, {53'd0, obs_q.pop_front()}, {53'd0, exp_q.pop_front()});
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, a;
        int n;
        vecs[0] = '{4, 32'h70023F06, 4, 0, 2, 2, 3, 8'h06};
        vecs[1] = '{4, 32'h7007AABB, 4, 0, 2, 7, 0, 8'hBB};
        vecs[2] = '{3, 32'h700B5500, 3, 0, 1, 3, 3, 8'h55};
        vecs[3] = '{3, 32'h72112200, 0, 1, 0, 0, 3, 8'h55};
        vecs[4] = '{3, 32'h71112200, 0, 2, 0, 0, 7, 8'hAA};
        for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;

        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        cyc(3);
        chk("rst_sda_oe", {63'd0, sda_oe}, 64'd0);
        chk("rst_wr_strobe", {63'd0, wr_strobe}, 64'd0);
        chk("rst_wr_addr", {61'd0, wr_addr}, 64'd0);
        chk("rst_wr_data", {56'd0, wr_data}, 64'd0);
        chk("rst_regs", regs_flat, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_nack", {56'd0, nack_cnt}, 64'd0);
        reset = 1'b0;
        cyc(5);

        for (int i = 0; i < 5; i++) begin
            set_tx(vecs[i].bytes, vecs[i].n);
            run_seg(1'b0);
            bus_stop();
            cyc(4);
            chk($sformatf("vec%0d_acks", i), 64'(seg_acks), 64'(vecs[i].acks));
            chk($sformatf("vec%0d_nack", i), {56'd0, nack_cnt}, 64'(vecs[i].nack));
            chk($sformatf("vec%0d_writes", i), 64'(obs_q.size()), 64'(vecs[i].writes));
            if (vecs[i].writes > 0 && obs_q.size() > 0)
                chk($sformatf("vec%0d_first_addr", i), {61'd0, obs_q[0][10:8]}, 64'(vecs[i].first));
            chk($sformatf("vec%0d_reg", i), {56'd0, regs_flat[8*vecs[i].ridx +: 8]}, {56'd0, vecs[i].rval});
            check_all($sformatf("vec%0d", i));
        end

        // STOP after five bits of a data byte discards it
        set_tx(32'h70050000, 2);
        run_seg(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        bus_stop();
        check_all("partial_stop");

        // Repeated START keeps busy high and the following write lands correctly
        set_tx(32'h70041100, 3);
        run_seg(1'b0);
        set_tx(32'h70062233, 4);
        run_seg(1'b1);
        bus_stop();
        check_all("rstart");

        // Reset in the middle of a DATA ACK slot
        set_tx(32'h70010000, 2);
        run_seg(1'b0);
        d = 8'h5A;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        cyc(2); sda_m = 1'b1; cyc(phase - 2); scl_m = 1'b1; cyc(2);
        chk("oe_in_data_ack", {63'd0, sda_oe}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_ack_sda_oe", {63'd0, sda_oe}, 64'd0);
        chk("rst_ack_busy", {63'd0, busy}, 64'd0);
        chk("rst_ack_regs", regs_flat, 64'd0);
        sda_m = 1'b1; scl_m = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(3);
        for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
        m_ptr = 0; m_nack = 0;
        exp_q.delete(); obs_q.delete();
        set_tx(32'h7000C300, 3);
        run_seg(1'b0);
        bus_stop();
        check_all("post_reset");

        // Randomized transactions, optionally chained with repeated STARTs
        for (int t = 0; t < 12; t++) begin
            phase = $urandom_range(8, 12);
            for (int s = 0; s < 1 + int'($urandom_range(0, 1)); s++) begin
                n = $urandom_range(1, 4);
                a = ($urandom_range(0, 3) != 0) ? WR_ADDR_BYTE : 8'($urandom_range(0, 255));
                tx_q.delete();
                tx_q.push_back(a);
                for (int i = 1; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
                run_seg(1'b0);
            end
            bus_stop();
            check_all($sformatf("rand%0d", t));
        end

        // NACK counter saturation at minimum SCL phase
        phase = 8;
        for (int t = 0; t < 300; t++) begin
            a = 8'($urandom_range(0, 255));
            if (a[7:1] == WR_ADDR_BYTE[7:1]) a = (t % 2 == 0) ? 8'h72 : 8'h71;
            tx_q.delete();
            tx_q.push_back(a);
            run_seg(1'b0);
            bus_stop();
        end
        check_all("saturate");
        chk("nack_saturated", {56'd0, nack_cnt}, 64'h0FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
